// File: rtl/mem_access_arbiter.sv
// Arbitrates the shared MAR/MDR/memory port between instruction fetch and the load/store unit,
// sequencing MAR load, memory enable, MFC wait and MDR capture, with timeout abort.
module mem_access_arbiter #(
  parameter int TIMEOUT      = 15,
  parameter int STARVE_LIMIT = 3
) (
  input  logic CLK,
  input  logic RESET,
  input  logic fetchReq,
  output logic fetchGnt,
  output logic fetchDone,
  input  logic dataReq,
  input  logic dataWr,
  output logic dataGnt,
  output logic dataDone,
  output logic MARselData,
  output logic MARinEn,
  output logic memEn,
  output logic memOp,
  input  logic MFC,
  output logic MDRreadEn,
  output logic busErr
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, ADDR, ACCESS, COMPLETE} state_t;

  state_t         state, nextState;
  logic           ownerData, wrReg, errReg;
  logic [TW-1:0]  timer;
  logic [SW-1:0]  streak;
  logic           anyReq, grantData, timeoutHit;

  assign anyReq     = fetchReq | dataReq;
  // Data wins ties unless fetch has already lost STARVE_LIMIT times in a row.
  assign grantData  = dataReq & (~fetchReq | (streak != SW'(STARVE_LIMIT)));
  assign timeoutHit = (timer == TW'(TIMEOUT - 1));

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state     <= IDLE;
      ownerData <= 1'b0;
      wrReg     <= 1'b0;
      errReg    <= 1'b0;
      timer     <= '0;
      streak    <= '0;
    end else begin
      state <= nextState;
      case (state)
        IDLE: begin
          if (anyReq) begin
            ownerData <= grantData;
            wrReg     <= grantData & dataWr;
            errReg    <= 1'b0;
            if (grantData && fetchReq)
              streak <= (streak == SW'(STARVE_LIMIT)) ? streak : streak + SW'(1);
            else
              streak <= '0;
          end
        end
        ADDR: timer <= '0;
        ACCESS: begin
          if (!MFC) begin
            if (timeoutHit) errReg <= 1'b1;
            else            timer  <= timer + TW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:     if (anyReq) nextState = ADDR;
      ADDR:     nextState = ACCESS;
      ACCESS:   if (MFC || timeoutHit) nextState = COMPLETE;
      COMPLETE: nextState = IDLE;
      default:  nextState = IDLE;
    endcase
  end

  always_comb begin
    fetchGnt   = 1'b0;
    dataGnt    = 1'b0;
    fetchDone  = 1'b0;
    dataDone   = 1'b0;
    MARselData = 1'b0;
    MARinEn    = 1'b0;
    memEn      = 1'b0;
    memOp      = 1'b0;
    MDRreadEn  = 1'b0;
    busErr     = 1'b0;
    case (state)
      ADDR: begin
        fetchGnt   = ~ownerData;
        dataGnt    = ownerData;
        MARselData = ownerData;
        MARinEn    = 1'b1;
      end
      ACCESS: begin
        fetchGnt   = ~ownerData;
        dataGnt    = ownerData;
        MARselData = ownerData;
        memEn      = 1'b1;
        memOp      = wrReg;
      end
      COMPLETE: begin
        fetchGnt   = ~ownerData;
        dataGnt    = ownerData;
        MARselData = ownerData;
        fetchDone  = ~ownerData;
        dataDone   = ownerData;
        MDRreadEn  = ~wrReg & ~errReg;
        busErr     = errReg;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Scenario bench for mem_access_arbiter: completions are scoreboarded as
// {fetchDone, dataDone, busErr, MDRreadEn} records against expectations queued at stimulus time.
module tb_mem_access_arbiter;

  logic CLK = 1'b0;
  logic RESET = 1'b0;
  logic fetchReq = 1'b0, dataReq = 1'b0, dataWr = 1'b0, MFC = 1'b0;
  logic fetchGnt, fetchDone, dataGnt, dataDone, MARselData, MARinEn;
  logic memEn, memOp, MDRreadEn, busErr;

  mem_access_arbiter dut (
    .CLK(CLK), .RESET(RESET),
    .fetchReq(fetchReq), .fetchGnt(fetchGnt), .fetchDone(fetchDone),
    .dataReq(dataReq), .dataWr(dataWr), .dataGnt(dataGnt), .dataDone(dataDone),
    .MARselData(MARselData), .MARinEn(MARinEn), .memEn(memEn), .memOp(memOp),
    .MFC(MFC), .MDRreadEn(MDRreadEn), .busErr(busErr)
  );

  always #5 CLK = ~CLK;

  int nCompared = 0, nMismatched = 0;
  int nFG, nDG, nMAR, nMem, nMemOp, nMDR, nBE, nFD, nDD, nSel;
  int totBoth = 0, totDoneNoGnt = 0;
  logic [3:0] expQ[$], obsQ[$];
  logic grantLog[$];
  logic prevGnt = 1'b0;

  function automatic logic [9:0] allOuts();
    return {fetchGnt, fetchDone, dataGnt, dataDone, MARselData, MARinEn, memEn, memOp, MDRreadEn, busErr};
  endfunction

  task automatic clearCounts();
    nFG = 0; nDG = 0; nMAR = 0; nMem = 0; nMemOp = 0;
    nMDR = 0; nBE = 0; nFD = 0; nDD = 0; nSel = 0;
  endtask

  // One clock: sample at the falling edge, accumulate activity and log grants/completions.
  task automatic cycle();
    @(negedge CLK);
    nFG   += fetchGnt ? 1 : 0;
    nDG   += dataGnt ? 1 : 0;
    nMAR  += MARinEn ? 1 : 0;
    nMem  += memEn ? 1 : 0;
    nMemOp += (memEn && memOp) ? 1 : 0;
    nMDR  += MDRreadEn ? 1 : 0;
    nBE   += busErr ? 1 : 0;
    nFD   += fetchDone ? 1 : 0;
    nDD   += dataDone ? 1 : 0;
    nSel  += MARselData ? 1 : 0;
    if (fetchGnt && dataGnt) totBoth++;
    if ((fetchDone && !fetchGnt) || (dataDone && !dataGnt)) totDoneNoGnt++;
    if ((fetchGnt || dataGnt) && !prevGnt) grantLog.push_back(dataGnt);
    prevGnt = fetchGnt | dataGnt;
    if (fetchDone || dataDone) obsQ.push_back({fetchDone, dataDone, busErr, MDRreadEn});
  endtask

  task automatic waitMemEn(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (memEn) begin ok = 1'b1; break; end
    end
  endtask

  task automatic waitDone(output bit ok);
    ok = 1'b0;
    for (int i = 0; i <= 40; i++) begin
      if (obsQ.size() > 0) begin ok = 1'b1; break; end
      cycle();
    end
  endtask

  task automatic test_reset();
    fetchReq = 1'b1; dataReq = 1'b1; MFC = 1'b1; RESET = 1'b0;
    repeat (3) cycle();
    nCompared++;
    if (allOuts() !== 10'b0) begin
      nMismatched++; $display("FAIL reset_outs: got %b want %b", allOuts(), 10'b0);
    end
    fetchReq = 1'b0; dataReq = 1'b0; MFC = 1'b0; RESET = 1'b1;
    cycle();
    nCompared++;
    if (allOuts() !== 10'b0) begin
      nMismatched++; $display("FAIL idle_outs: got %b want %b", allOuts(), 10'b0);
    end
  endtask

  task automatic test_fetch_read();
    bit ok;
    logic [3:0] e, g;
    clearCounts();
    fetchReq = 1'b1;
    expQ.push_back(4'b1001);
    waitMemEn(ok);
    cycle();
    MFC = 1'b1; cycle(); MFC = 1'b0;
    waitDone(ok);
    fetchReq = 1'b0;
    repeat (2) cycle();
    nCompared++;
    if (!ok) begin nMismatched++; $display("FAIL fetch_done: no Done within budget"); end
    else begin
      e = expQ.pop_front(); g = obsQ.pop_front();
      if (g !== e) begin nMismatched++; $display("FAIL fetch_rec: got %b want %b", g, e); end
    end
    nCompared++; if (nFG !== 4)  begin nMismatched++; $display("FAIL fetch_gnt_cycles: got %0d want 4", nFG); end
    nCompared++; if (nMAR !== 1) begin nMismatched++; $display("FAIL fetch_marin: got %0d want 1", nMAR); end
    nCompared++; if (nMem !== 2) begin nMismatched++; $display("FAIL fetch_memen: got %0d want 2", nMem); end
    nCompared++; if (nMemOp !== 0) begin nMismatched++; $display("FAIL fetch_memop: got %0d want 0", nMemOp); end
    nCompared++; if (nMDR !== 1 || nFD !== 1) begin nMismatched++; $display("FAIL fetch_mdr_done: got mdr %0d done %0d want 1 1", nMDR, nFD); end
    nCompared++; if (nBE !== 0 || nDG !== 0 || nSel !== 0) begin nMismatched++; $display("FAIL fetch_quiet: got be %0d dgnt %0d sel %0d want 0 0 0", nBE, nDG, nSel); end
  endtask

  task automatic test_data_write();
    bit ok;
    logic [3:0] e, g;
    clearCounts();
    dataReq = 1'b1; dataWr = 1'b1;
    expQ.push_back(4'b0100);
    cycle();
    dataWr = 1'b0;
    cycle();
    nCompared++;
    if (!(memEn && memOp)) begin nMismatched++; $display("FAIL write_access: got memEn %b memOp %b want 1 1", memEn, memOp); end
    MFC = 1'b1; cycle(); MFC = 1'b0;
    waitDone(ok);
    dataReq = 1'b0;
    repeat (2) cycle();
    nCompared++;
    if (!ok) begin nMismatched++; $display("FAIL write_done: no Done within budget"); end
    else begin
      e = expQ.pop_front(); g = obsQ.pop_front();
      if (g !== e) begin nMismatched++; $display("FAIL write_rec: got %b want %b", g, e); end
    end
    nCompared++; if (nDG !== 3 || nSel !== 3) begin nMismatched++; $display("FAIL write_gnt_sel: got gnt %0d sel %0d want 3 3", nDG, nSel); end
    nCompared++; if (nMem !== 1 || nMemOp !== 1) begin nMismatched++; $display("FAIL write_memop: got memEn %0d memOp %0d want 1 1", nMem, nMemOp); end
    nCompared++; if (nMDR !== 0 || nFG !== 0) begin nMismatched++; $display("FAIL write_mdr: got mdr %0d fgnt %0d want 0 0", nMDR, nFG); end
  endtask

  task automatic test_starvation();
    bit ok;
    logic [7:0] gotOrd;
    logic [3:0] e, g;
    clearCounts();
    grantLog.delete();
    fetchReq = 1'b1; dataReq = 1'b1; dataWr = 1'b0;
    for (int i = 0; i < 8; i++) begin
      expQ.push_back((i % 4 == 3) ? 4'b1001 : 4'b0101);
      waitMemEn(ok);
      if (!ok) break;
      MFC = 1'b1; cycle(); MFC = 1'b0;
    end
    fetchReq = 1'b0; dataReq = 1'b0;
    repeat (3) cycle();
    nCompared++;
    if (grantLog.size() != 8) begin
      nMismatched++; $display("FAIL starve_grants: got %0d grants want 8", grantLog.size());
    end else begin
      gotOrd = '0;
      for (int i = 0; i < 8; i++) gotOrd[i] = grantLog[i];
      if (gotOrd !== 8'b0111_0111) begin nMismatched++; $display("FAIL starve_order: got %b want %b", gotOrd, 8'b0111_0111); end
    end
    for (int i = 0; i < 8; i++) begin
      nCompared++;
      if (obsQ.size() == 0 || expQ.size() == 0) begin
        nMismatched++; $display("FAIL starve_rec%0d: missing completion", i);
      end else begin
        e = expQ.pop_front(); g = obsQ.pop_front();
        if (g !== e) begin nMismatched++; $display("FAIL starve_rec%0d: got %b want %b", i, g, e); end
      end
    end
    expQ.delete(); obsQ.delete();
  endtask

  task automatic test_timeout();
    bit ok;
    logic [3:0] e, g;
    clearCounts();
    fetchReq = 1'b1;
    expQ.push_back(4'b1010);
    waitMemEn(ok);
    waitDone(ok);
    fetchReq = 1'b0;
    repeat (2) cycle();
    nCompared++;
    if (!ok) begin nMismatched++; $display("FAIL tmo_done: no Done within budget"); end
    else begin
      e = expQ.pop_front(); g = obsQ.pop_front();
      if (g !== e) begin nMismatched++; $display("FAIL tmo_rec: got %b want %b", g, e); end
    end
    nCompared++; if (nMem !== 15) begin nMismatched++; $display("FAIL tmo_memen: got %0d want 15", nMem); end
    nCompared++; if (nBE !== 1 || nMDR !== 0) begin nMismatched++; $display("FAIL tmo_err: got be %0d mdr %0d want 1 0", nBE, nMDR); end

    clearCounts();
    fetchReq = 1'b1;
    expQ.push_back(4'b1001);
    waitMemEn(ok);
    repeat (14) cycle();
    MFC = 1'b1; cycle(); MFC = 1'b0;
    waitDone(ok);
    fetchReq = 1'b0;
    repeat (2) cycle();
    nCompared++;
    if (!ok) begin nMismatched++; $display("FAIL mfc15_done: no Done within budget"); end
    else begin
      e = expQ.pop_front(); g = obsQ.pop_front();
      if (g !== e) begin nMismatched++; $display("FAIL mfc15_rec: got %b want %b", g, e); end
    end
    nCompared++; if (nMem !== 15 || nBE !== 0) begin nMismatched++; $display("FAIL mfc15_memen: got memEn %0d be %0d want 15 0", nMem, nBE); end
  endtask

  task automatic test_reset_mid_access();
    bit ok;
    int doneBefore;
    logic [3:0] e, g;
    clearCounts();
    fetchReq = 1'b1; dataReq = 1'b1; dataWr = 1'b0;
    for (int i = 0; i < 2; i++) begin
      expQ.push_back(4'b0101);
      waitMemEn(ok);
      MFC = 1'b1; cycle(); MFC = 1'b0;
    end
    waitMemEn(ok);
    doneBefore = nFD + nDD;
    RESET = 1'b0;
    cycle();
    nCompared++;
    if (allOuts() !== 10'b0) begin nMismatched++; $display("FAIL rst_mid_outs: got %b want %b", allOuts(), 10'b0); end
    RESET = 1'b1;
    expQ.push_back(4'b0101);
    waitMemEn(ok);
    nCompared++;
    if (!ok || grantLog.size() == 0) begin nMismatched++; $display("FAIL rst_regrant: no grant after reset"); end
    else if (grantLog[grantLog.size()-1] !== 1'b1) begin
      nMismatched++; $display("FAIL rst_streak: got grant data=%b want 1", grantLog[grantLog.size()-1]);
    end
    nCompared++;
    if (nFD + nDD !== doneBefore) begin nMismatched++; $display("FAIL rst_no_done: got %0d dones want %0d", nFD + nDD, doneBefore); end
    MFC = 1'b1; cycle(); MFC = 1'b0;
    fetchReq = 1'b0; dataReq = 1'b0;
    repeat (2) cycle();
    for (int i = 0; i < 3; i++) begin
      nCompared++;
      if (obsQ.size() == 0 || expQ.size() == 0) begin
        nMismatched++; $display("FAIL rst_rec%0d: missing completion", i);
      end else begin
        e = expQ.pop_front(); g = obsQ.pop_front();
        if (g !== e) begin nMismatched++; $display("FAIL rst_rec%0d: got %b want %b", i, g, e); end
      end
    end
    expQ.delete(); obsQ.delete();
  endtask

  task automatic test_ignored_inputs();
    bit ok;
    logic [3:0] e, g;
    clearCounts();
    MFC = 1'b1; cycle();
    fetchReq = 1'b1;
    expQ.push_back(4'b1001);
    cycle();
    cycle();
    MFC = 1'b0; fetchReq = 1'b0;
    repeat (2) cycle();
    MFC = 1'b1; cycle(); MFC = 1'b0;
    waitDone(ok);
    repeat (2) cycle();
    nCompared++;
    if (!ok) begin nMismatched++; $display("FAIL ign_done: no Done within budget"); end
    else begin
      e = expQ.pop_front(); g = obsQ.pop_front();
      if (g !== e) begin nMismatched++; $display("FAIL ign_rec: got %b want %b", g, e); end
    end
    nCompared++; if (nMem !== 3) begin nMismatched++; $display("FAIL ign_memen: got %0d want 3", nMem); end
    nCompared++; if (nFG !== 5 || nFD !== 1) begin nMismatched++; $display("FAIL ign_gnt: got gnt %0d done %0d want 5 1", nFG, nFD); end
  endtask

  initial begin
    test_reset();
    test_fetch_read();
    test_data_write();
    test_starvation();
    test_timeout();
    test_reset_mid_access();
    test_ignored_inputs();
    nCompared++;
    if (totBoth !== 0) begin nMismatched++; $display("FAIL both_gnt: got %0d cycles want 0", totBoth); end
    nCompared++;
    if (totDoneNoGnt !== 0) begin nMismatched++; $display("FAIL done_no_gnt: got %0d cycles want 0", totDoneNoGnt); end
    nCompared++;
    if (expQ.size() != 0 || obsQ.size() != 0) begin
      nMismatched++; $display("FAIL sb_leftover: got exp %0d obs %0d want 0 0", expQ.size(), obsQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
